// File: rtl/filter_pkg.sv
// filter_pkg: shared types and defaults for the filter sequencer slice.
package filter_pkg;
    localparam int DEF_NUM_MODES = 4;
    typedef enum logic [2:0] {BYPASS, COOL, WARM, GRAY} filter_mode_e;
    typedef logic [15:0] rgb565_t;
    typedef enum logic [1:0] {WAIT_SYNC, RUN, PENDING} seq_state_e;
endpackage

// File: rtl/fb_write_mux.sv
// fb_write_mux: registered NUM_MODES:1 stream mux onto the frame-buffer write port.
// gate_i low suppresses the write enable while address/data still follow the selection.
module fb_write_mux
    import filter_pkg::*;
#(
    parameter int NUM_MODES = DEF_NUM_MODES,
    parameter int ADDR_W    = 17,
    parameter int SEL_W     = NUM_MODES > 1 ? $clog2(NUM_MODES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        gate_i,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic [NUM_MODES-1:0]        we_i,
    input  logic [NUM_MODES*ADDR_W-1:0] addr_i,
    input  logic [NUM_MODES*16-1:0]     data_i,
    output logic                        we_o,
    output logic [ADDR_W-1:0]           addr_o,
    output rgb565_t                     data_o
);
    logic [ADDR_W-1:0] addr_a [NUM_MODES];
    rgb565_t           data_a [NUM_MODES];
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    rgb565_t           data_q;

    for (genvar i = 0; i < NUM_MODES; i++) begin : g_split
        assign addr_a[i] = addr_i[i*ADDR_W +: ADDR_W];
        assign data_a[i] = data_i[i*16 +: 16];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= gate_i && we_i[sel_i];
            addr_q <= addr_a[sel_i];
            data_q <= data_a[sel_i];
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
endmodule

// File: rtl/filter_sequencer.sv
// filter_sequencer: frame-synchronous filter-mode controller driving the frame-buffer write port.
// Optional auto-cycling of modes every AUTO_FRAMES frames is built with FILTER_AUTO_CYCLE_EN.
module filter_sequencer
    import filter_pkg::*;
#(
    parameter  int IMG_WIDTH   = 320,
    parameter  int IMG_HEIGHT  = 240,
    parameter  int NUM_MODES   = DEF_NUM_MODES,
    parameter  int AUTO_FRAMES = 60,
    localparam int ADDR_W      = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        mode_req_valid,
    input  logic [2:0]                  mode_req,
    output logic                        mode_req_ready,
    input  logic                        auto_en,
    input  logic [NUM_MODES-1:0]        filt_we,
    input  logic [NUM_MODES*ADDR_W-1:0] filt_addr,
    input  logic [NUM_MODES*16-1:0]     filt_data,
    output logic                        fb_we,
    output logic [ADDR_W-1:0]           fb_addr,
    output rgb565_t                     fb_data,
    output logic [2:0]                  active_mode,
    output logic                        req_err
);
    localparam int SEL_W = NUM_MODES > 1 ? $clog2(NUM_MODES) : 1;

    seq_state_e state_q, state_d;
    logic [2:0] active_q, active_d;
    logic [2:0] pend_q, pend_d;
    logic       err_q, err_d;

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int CNT_W = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       next_mode;

    assign next_mode = (int'(active_q) == NUM_MODES-1) ? 3'd0 : active_q + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_auto;
    assign unused_auto = auto_en ^ (AUTO_FRAMES < 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_SYNC;
            active_q <= 3'(BYPASS);
            pend_q   <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        err_d    = 1'b0;
`ifdef FILTER_AUTO_CYCLE_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            WAIT_SYNC: state_d = frame_start ? RUN : WAIT_SYNC;
            RUN: begin
                if (mode_req_valid && int'(mode_req) < NUM_MODES) begin
                    pend_d  = mode_req;
                    state_d = PENDING;
                end else if (mode_req_valid) begin
                    err_d = 1'b1;
                end
`ifdef FILTER_AUTO_CYCLE_EN
                // A request latched this cycle waits for the next boundary; auto-cycling still advances here.
                if (!auto_en) begin
                    cnt_d = '0;
                end else if (frame_start && int'(cnt_q) == AUTO_FRAMES-1) begin
                    cnt_d    = '0;
                    active_d = next_mode;
                end else if (frame_start) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            PENDING: begin
                if (frame_start) begin
                    active_d = pend_q;
                    state_d  = RUN;
`ifdef FILTER_AUTO_CYCLE_EN
                    cnt_d    = '0;
`endif
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    assign mode_req_ready = (state_q == RUN);
    assign active_mode    = active_q;
    assign req_err        = err_q;

    fb_write_mux #(
        .NUM_MODES (NUM_MODES),
        .ADDR_W    (ADDR_W),
        .SEL_W     (SEL_W)
    ) u_mux (
        .clk    (clk),
        .reset  (reset),
        .gate_i (state_q != WAIT_SYNC),
        .sel_i  (active_q[SEL_W-1:0]),
        .we_i   (filt_we),
        .addr_i (filt_addr),
        .data_i (filt_data),
        .we_o   (fb_we),
        .addr_o (fb_addr),
        .data_o (fb_data)
    );
endmodule
